// File: rtl/sam_dmem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sam_dmem_arb                                                   |
// | Brief   : Two-port (core C / host H) arbiter owning a single-port 32-bit |
// |           data memory. Registered one-cycle grant handshake, round-robin |
// |           by default; SAM_DMEM_ARB_FIXED_PRIO_EN selects core-first      |
// |           priority with a host starvation bound of MAX_WAIT cycles.      |
// |           Counts cycles with both ports requesting (saturating).         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sam_dmem_arb #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [31:0]       c_wdata_i,
  output logic              c_gnt_o,
  output logic [31:0]       c_rdata_o,
  input  logic              h_req_i,
  input  logic              h_we_i,
  input  logic [ADDR_W-1:0] h_addr_i,
  input  logic [31:0]       h_wdata_i,
  output logic              h_gnt_o,
  output logic [31:0]       h_rdata_o,
  output logic [15:0]       conflict_cnt_o
);

  localparam int          c_DEPTH   = 2**ADDR_W;
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  // The host wait counter is 4 bits wide, so the bound must fit in it.
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("sam_dmem_arb: MAX_WAIT must be in 1..15");
  end

  logic [31:0]       mem_q [c_DEPTH];
  logic              c_gnt_q, h_gnt_q;
  logic [31:0]       c_rdata_q, h_rdata_q;
  logic [15:0]       cnt_q, cnt_d;

  logic              w_both;
  logic              w_host_wins;
  logic              w_sel_c, w_sel_h;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;

  assign w_both = c_req_i & h_req_i;

`ifdef SAM_DMEM_ARB_FIXED_PRIO_EN
  // Core-first: host only wins a conflict once it has waited MAX_WAIT edges.
  logic [3:0] wait_q, wait_d;

  assign w_host_wins = (wait_q == 4'(MAX_WAIT));

  // Count edges on which the host asks but is passed over; any host access clears.
  always_comb begin
    wait_d = wait_q;
    if (w_sel_h) begin
      wait_d = 4'd0;
    end else if (h_req_i && (wait_q != 4'hF)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // Host wait counter register.
  always_ff @(posedge clk) begin
    if (RN) begin
      wait_q <= 4'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  // Round-robin: last_q = 1 means the host made the most recent access.
  logic last_q, last_d;

  assign w_host_wins = ~last_q;

  // Remember which port executed last; idle edges leave it unchanged.
  always_comb begin
    last_d = last_q;
    if (w_sel_h) begin
      last_d = 1'b1;
    end else if (w_sel_c) begin
      last_d = 1'b0;
    end
  end

  // Round-robin pointer register; resets to host so the core wins the first conflict.
  always_ff @(posedge clk) begin
    if (RN) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Pick at most one port per edge; nothing executes while reset is asserted.
  always_comb begin
    w_sel_c = 1'b0;
    w_sel_h = 1'b0;
    if (!RN) begin
      if (w_both) begin
        w_sel_h = w_host_wins;
        w_sel_c = ~w_host_wins;
      end else begin
        w_sel_c = c_req_i;
        w_sel_h = h_req_i;
      end
    end
  end

  // Steer the selected port's write onto the single memory port.
  always_comb begin
    w_wr_en = (w_sel_c & c_we_i) | (w_sel_h & h_we_i);
    w_addr  = w_sel_h ? h_addr_i  : c_addr_i;
    w_wdata = w_sel_h ? h_wdata_i : c_wdata_i;
  end

  // Saturating conflict counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (w_both && (cnt_q != c_CNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[w_addr] <= w_wdata;
    end
  end

  // Grant pulses, read-data capture (held between reads) and conflict counter.
  always_ff @(posedge clk) begin
    if (RN) begin
      c_gnt_q   <= 1'b0;
      h_gnt_q   <= 1'b0;
      c_rdata_q <= 32'd0;
      h_rdata_q <= 32'd0;
      cnt_q     <= 16'd0;
    end else begin
      c_gnt_q <= w_sel_c;
      h_gnt_q <= w_sel_h;
      cnt_q   <= cnt_d;
      if (w_sel_c && !c_we_i) begin
        c_rdata_q <= mem_q[c_addr_i];
      end
      if (w_sel_h && !h_we_i) begin
        h_rdata_q <= mem_q[h_addr_i];
      end
    end
  end

  assign c_gnt_o        = c_gnt_q;
  assign h_gnt_o        = h_gnt_q;
  assign c_rdata_o      = c_rdata_q;
  assign h_rdata_o      = h_rdata_q;
  assign conflict_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sam_dmem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sam_dmem_arb                                                |
// | Brief   : Self-checking bench for sam_dmem_arb: directed scenarios with  |
// |           literal expectations plus randomized two-port traffic compared |
// |           every cycle against a behavioural model.                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sam_dmem_arb;

  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              RN;
  logic              c_req, c_we, h_req, h_we;
  logic [ADDR_W-1:0] c_addr, h_addr;
  logic [31:0]       c_wdata, h_wdata;
  logic              c_gnt, h_gnt;
  logic [31:0]       c_rdata, h_rdata;
  logic [15:0]       conflict_cnt;

  int tests = 0;
  int fails = 0;

  sam_dmem_arb #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .RN            (RN),
    .c_req_i       (c_req),
    .c_we_i        (c_we),
    .c_addr_i      (c_addr),
    .c_wdata_i     (c_wdata),
    .c_gnt_o       (c_gnt),
    .c_rdata_o     (c_rdata),
    .h_req_i       (h_req),
    .h_we_i        (h_we),
    .h_addr_i      (h_addr),
    .h_wdata_i     (h_wdata),
    .h_gnt_o       (h_gnt),
    .h_rdata_o     (h_rdata),
    .conflict_cnt_o(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [2**ADDR_W];
  bit          m_known [2**ADDR_W];
  int          m_cnt = 0;
`ifdef SAM_DMEM_ARB_FIXED_PRIO_EN
  int          m_wait = 0;
`else
  bit          m_last_h = 1'b1;
`endif
  logic        e_cg = 1'b0, e_hg = 1'b0;
  logic [31:0] e_cr = 32'd0, e_hr = 32'd0;
  bit          e_cr_ok = 1'b1, e_hr_ok = 1'b1;

  always @(posedge clk) begin
    int win;  // 0 = idle, 1 = core, 2 = host
    if (RN) begin
      e_cg = 1'b0; e_hg = 1'b0;
      e_cr = 32'd0; e_hr = 32'd0;
      e_cr_ok = 1'b1; e_hr_ok = 1'b1;
      m_cnt = 0;
`ifdef SAM_DMEM_ARB_FIXED_PRIO_EN
      m_wait = 0;
`else
      m_last_h = 1'b1;
`endif
    end else begin
      win = 0;
      if (c_req && h_req) begin
        if (m_cnt < 65535) m_cnt++;
`ifdef SAM_DMEM_ARB_FIXED_PRIO_EN
        win = (m_wait == MAX_WAIT) ? 2 : 1;
`else
        win = m_last_h ? 1 : 2;
`endif
      end else if (c_req) begin
        win = 1;
      end else if (h_req) begin
        win = 2;
      end
      e_cg = (win == 1);
      e_hg = (win == 2);
      if (win == 1) begin
        if (c_we) begin
          m_mem[c_addr] = c_wdata; m_known[c_addr] = 1'b1;
        end else begin
          e_cr = m_mem[c_addr]; e_cr_ok = m_known[c_addr];
        end
      end
      if (win == 2) begin
        if (h_we) begin
          m_mem[h_addr] = h_wdata; m_known[h_addr] = 1'b1;
        end else begin
          e_hr = m_mem[h_addr]; e_hr_ok = m_known[h_addr];
        end
      end
`ifdef SAM_DMEM_ARB_FIXED_PRIO_EN
      if (win == 2) m_wait = 0;
      else if (h_req && m_wait < 15) m_wait++;
`else
      if (win != 0) m_last_h = (win == 2);
`endif
    end
    #1;
    check("c_gnt", 32'(c_gnt), 32'(e_cg));
    check("h_gnt", 32'(h_gnt), 32'(e_hg));
    if (e_cr_ok) check("c_rdata", c_rdata, e_cr);
    if (e_hr_ok) check("h_rdata", h_rdata, e_hr);
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; issues one request, waits (bounded) for its grant, drops req.
  task automatic access(input bit host, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, output logic [31:0] rd);
    bit ok = 1'b0;
    if (host) begin h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d; end
    else      begin c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d; end
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (host ? h_gnt : c_gnt) ok = 1'b1;
    end
    rd = host ? h_rdata : c_rdata;
    if (host) h_req = 1'b0; else c_req = 1'b0;
    check(host ? "h_access_gnt" : "c_access_gnt", 32'(ok), 32'd1);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 3));
    return ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
  endfunction

  task automatic random_phase(input int n, input int rc, input int rh);
    bit cp = 1'b0, hp = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      RN = 1'b0;
      if (c_gnt) cp = 1'b0;
      if (h_gnt) hp = 1'b0;
      if (!cp && $urandom_range(0, 99) < rc) begin
        cp = 1'b1; c_we = 1'($urandom_range(0, 1)); c_addr = rand_addr(); c_wdata = $urandom();
      end
      if (!hp && $urandom_range(0, 99) < rh) begin
        hp = 1'b1; h_we = 1'($urandom_range(0, 1)); h_addr = rand_addr(); h_wdata = $urandom();
      end
      c_req = cp;
      h_req = hp;
      if ($urandom_range(0, 299) == 0) RN = 1'b1;
    end
    @(negedge clk);
    RN = 1'b0; c_req = 1'b0; h_req = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rd;
    string       seq;
`ifdef SAM_DMEM_ARB_FIXED_PRIO_EN
    seq = "CCCCHCCCCH";
`else
    seq = "CHCHCHCHCH";
`endif
    RN = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    repeat (3) @(negedge clk);
    RN = 1'b0;
    check("rst_c_gnt", 32'(c_gnt), 32'd0);
    check("rst_h_gnt", 32'(h_gnt), 32'd0);
    check("rst_c_rdata", c_rdata, 32'd0);
    check("rst_h_rdata", h_rdata, 32'd0);
    check("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);

    // Core write then read of address 3.
    access(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, rd);
    check("wr3_h_gnt", 32'(h_gnt), 32'd0);
    @(negedge clk);
    check("wr3_gnt_one_cycle", 32'(c_gnt), 32'd0);
    access(1'b0, 1'b0, 5'd3, 32'd0, rd);
    check("rd3_data", rd, 32'hDEAD_BEEF);
    check("rd3_h_gnt", 32'(h_gnt), 32'd0);

    // Both ports hold requests from reset release.
    @(negedge clk);
    RN = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 5'd3;
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd3;
    @(negedge clk);
    RN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("seq_c_gnt", 32'(c_gnt), 32'(seq[i] == "C"));
      check("seq_h_gnt", 32'(h_gnt), 32'(seq[i] == "H"));
      check("seq_conflict_cnt", 32'(conflict_cnt), 32'(i + 1));
    end
    c_req = 1'b0; h_req = 1'b0;

    // Host write and core read of address 7 on the same edge.
    @(negedge clk);
    access(1'b0, 1'b1, 5'd7, 32'hAAAA_5555, rd);
    RN = 1'b1;
    @(negedge clk);
    RN = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 5'd7;
    h_req = 1'b1; h_we = 1'b1; h_addr = 5'd7; h_wdata = 32'h1234_5678;
    @(negedge clk);
    check("raw_core_first", 32'(c_gnt), 32'd1);
    check("raw_host_waits", 32'(h_gnt), 32'd0);
    check("raw_old_data", c_rdata, 32'hAAAA_5555);
    c_req = 1'b0;
    for (int i = 0; i < 16 && !h_gnt; i++) @(negedge clk);
    check("raw_host_gnt", 32'(h_gnt), 32'd1);
    h_req = 1'b0;
    access(1'b0, 1'b0, 5'd7, 32'd0, rd);
    check("raw_new_data", rd, 32'h1234_5678);

    // Reset while a core write to address 0 is pending.
    access(1'b0, 1'b1, 5'd0, 32'h0BAD_F00D, rd);
    RN = 1'b1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 5'd0; c_wdata = 32'hFFFF_FFFF;
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd1;
    @(negedge clk);
    RN = 1'b0; c_req = 1'b0; h_req = 1'b0;
    check("midrst_no_c_gnt", 32'(c_gnt), 32'd0);
    check("midrst_no_h_gnt", 32'(h_gnt), 32'd0);
    check("midrst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    access(1'b0, 1'b0, 5'd0, 32'd0, rd);
    check("midrst_no_commit", rd, 32'h0BAD_F00D);

    // Randomized traffic at several load mixes.
    random_phase(1000, 90, 90);
    random_phase(1000, 30, 80);
    random_phase(1000, 80, 10);
    random_phase(1000, 50, 50);

    // Saturation of the conflict counter.
    @(negedge clk);
    RN = 1'b1;
    @(negedge clk);
    RN = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 5'd3;
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd7;
    repeat (70000) @(negedge clk);
    check("sat_conflict_cnt", 32'(conflict_cnt), 32'h0000_FFFF);
    c_req = 1'b0; h_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sam_dmem_arb.md
# sam_dmem_arb

Two-port arbiter and owner of the single-port data memory for the sam_rv32i pipeline. It shares one 32-bit-wide memory between the core MEM stage (port C) and the host/loader port (port H) with a registered request/grant handshake. Default policy is round-robin. A compile-time option switches it to core-first priority with a host starvation bound. The block also counts arbitration conflicts for bring-up visibility.

## Interface
- ADDR_W, 5: word-address width; memory depth is 2**ADDR_W words.
- MAX_WAIT, 4: host wait bound, in cycles, in fixed-priority mode (1..15).
- clk  in  1  clock; all logic is on the rising edge.
- RN  in  1  reset, synchronous, active-high.
- c_req  in  1  core request; held with c_we/c_addr/c_wdata stable until c_gnt.
- c_we  in  1  1 = write, 0 = read.
- c_addr  in  ADDR_W  core word address.
- c_wdata  in  32  core write data.
- c_gnt  out  1  one-cycle pulse: the core access executed on the preceding edge.
- c_rdata  out  32  read data, valid while c_gnt=1 and the access was a read.
- h_req, h_we, h_addr, h_wdata, h_gnt, h_rdata: same as the c_* ports, for the host.
- conflict_cnt  out  16  saturating count of cycles with both requests pending.

## Operation
- Exactly one memory access executes per clock edge, at most.
- An access executes on an edge where RN=0 and the port is selected. On that edge:
  - a write commits mem[addr] <= wdata;
  - a read captures mem[addr] into x_rdata.
- Selection on each edge:
  - only c_req high: the core is selected;
  - only h_req high: the host is selected;
  - neither: idle;
  - both: resolved by policy.
- Round-robin policy (default):
  - a 1-bit pointer `last` holds the most recently selected port;
  - on a conflict, the port other than `last` is selected;
  - `last` updates on every executed access.
- x_gnt is registered. It is high for exactly the one cycle after the edge on which that port's access executed.
- If req is still high while gnt is high, that is a new request, arbitrated on the next edge. A requester holding req therefore gets back-to-back accesses when uncontested.
- A requester drops req in the cycle gnt is seen, unless it wants another access.
- Read-after-write to the same address by consecutive accesses returns the new data. Write-then-read never happen on the same edge.
- x_rdata holds its last value when gnt=0.
- conflict_cnt increments on every edge with c_req=h_req=1 and RN=0. It saturates at 16'hFFFF.

## Timing
- Latency: request seen on edge N, access executes on edge N, gnt/rdata high in cycle N+1. Minimum 1 cycle from req to gnt.
- Contested requester: latency of 2 cycles in round-robin mode.
- Reset values:
  - c_gnt=0, h_gnt=0, c_rdata=0, h_rdata=0;
  - conflict_cnt=0;
  - `last`=H, so the core wins the first conflict;
  - wait counter=0.
- Memory contents are not reset.
- Reset mid-operation: a request pending on the reset edge does not execute (no write commit) and receives no gnt. It re-arbitrates from the first edge after RN falls.
- Address range: c_addr/h_addr index all 2**ADDR_W words directly. There is no out-of-range case.

## Configuration
- SAM_DMEM_ARB_FIXED_PRIO_EN defined: core-first priority with a starvation bound.
  - A 4-bit host wait counter increments on each edge where h_req=1 and the host is not selected.
  - When the counter equals MAX_WAIT, the host wins the next conflict.
  - The counter clears on any host access.
  - `last` is unused.
- Not defined: round-robin as above; the wait counter is not instantiated.

## Test plan
- Reset, then core write addr 3 = 32'hDEAD_BEEF, then core read addr 3 -> c_gnt pulses one cycle after each request; read returns c_rdata=32'hDEADBEEF; h_gnt stays 0.
- Both ports hold req continuously from reset release, round-robin:
  - grants alternate C,H,C,H starting with C;
  - each port gets one access per 2 cycles;
  - conflict_cnt increments every cycle.
- Host writes addr 7 = 32'h1234_5678 on the same edge the core requests a read of addr 7 -> the core (first conflict winner) reads the old value; the next core read returns 32'h12345678.
- Fixed-priority build, MAX_WAIT=4, both req held -> core granted 4 consecutive times, then host once, then the pattern repeats.
- Assert RN for one cycle while the core has a write to addr 0 pending -> no commit (a read of addr 0 returns the pre-reset value), no c_gnt, conflict_cnt=0 after reset.
- Hold both requests for 70000 cycles -> conflict_cnt saturates at 16'hFFFF and does not wrap.
